// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//  state_e      : arbiter FSM states (IDLE, BUSY, RESP)
//  PORT_IF/DM   : port identifiers, also the address-mux select encoding
//  pick_grant() : round-robin choice between the two requesters
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // On contention the port that did not win last time is chosen;
  // a lone requester always wins.
  function automatic logic pick_grant(input logic if_req,
                                      input logic dm_req,
                                      input logic last_grant);
    if (if_req && dm_req) return ~last_grant;
    else if (dm_req)      return PORT_DM;
    else                  return PORT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Generic 2:1 mux used for the memory address path.
//  in0  : selected when sel=0
//  in1  : selected when sel=1
//  sel  : select
//  out  : selected input
module mem_port_arbiter_mux2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (DM).
// Round-robin arbitration, one access in flight at a time.
//  clk, reset          : clock, synchronous active-high reset
//  if_req/if_addr      : IF read request (level) and address
//  if_rdata/if_done    : IF read data (held) and 1-cycle completion pulse
//  dm_req/dm_we/...    : DM request, write enable, address, write data
//  dm_rdata/dm_done    : DM read data (held) and 1-cycle completion pulse
//  mem_en/mem_we       : memory access enable / write enable
//  mem_addr/mem_wdata  : memory address (muxed by sel) and write data
//  mem_rdata/mem_r     : memory read data and ready
//  sel                 : address-mux select, 0=IF 1=DM
//
// Handshake: a requester raises req with stable address/data and holds it
// until it sees its done pulse; it drops req on the edge that samples
// done=1. The memory completes an access in the BUSY cycle where mem_r=1;
// mem_r in any other state is ignored.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_r,
  output logic              sel
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    if_done      = 1'b0;
    dm_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          sel_d        = pick_grant(if_req, dm_req, last_grant_q);
          last_grant_d = sel_d;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_en = 1'b1;
        mem_we = sel_q & dm_we;
        if (mem_r) begin
          // Writes complete without touching the read-data registers.
          if (sel_q == PORT_IF)  if_rdata_d = mem_rdata;
          else if (!dm_we)       dm_rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if_done = (sel_q == PORT_IF);
        dm_done = (sel_q == PORT_DM);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= PORT_IF;
      last_grant_q <= PORT_DM;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  mem_port_arbiter_mux2 #(.W(ADDR_W)) u_addr_mux (
    .in0 (if_addr),
    .in1 (dm_addr),
    .sel (sel_q),
    .out (mem_addr)
  );

  assign sel       = sel_q;
  assign mem_wdata = dm_wdata;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_done, dm_done;
  logic        mem_en, mem_we, mem_r, sel;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // {port, data} of each completion the reference model expects, in order
  logic [16:0] exp_q[$];
  logic        grant_log[$];

  // memory model controls
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  bit          fixed_en = 1'b0;
  logic [15:0] fixed_d = 16'h0;

  // reference model state
  logic        ref_last;
  logic [15:0] ref_if_rd, ref_dm_rd;
  logic        cur_g;
  int          busy_cnt;
  logic        prev_en, prev_if_req, prev_dm_req;
  logic        expect_done;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_r     (mem_r),
    .sel       (sel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic if_access(input logic [15:0] a);
    int t = 0;
    if_addr = a;
    if_req  = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!if_done && t < 200);
    check("if_done_timeout", {31'd0, if_done}, 32'd1);
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [15:0] a, input logic [15:0] d);
    int t = 0;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = d;
    dm_req   = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!dm_done && t < 200);
    check("dm_done_timeout", {31'd0, dm_done}, 32'd1);
    @(posedge clk);
    #1 dm_req = 1'b0;
  endtask

  // ---------------- memory model + reference + scoreboard ----------------
  always @(negedge clk) begin
    logic        g;
    logic        new_r;
    logic [15:0] new_d;
    logic [16:0] e;
    if (reset) begin
      exp_q.delete();
      expect_done = 1'b0;
      ref_last    = 1'b1;
      ref_if_rd   = 16'h0;
      ref_dm_rd   = 16'h0;
      busy_cnt    = 0;
      cur_g       = 1'b0;
      prev_en     = 1'b0;
      mem_r       = 1'b0;
      mem_rdata   = 16'h0;
    end else begin
      // completion checks
      check("done_exclusive", {31'd0, if_done & dm_done}, 32'd0);
      check("done_timing", {31'd0, if_done | dm_done}, {31'd0, expect_done});
      if (if_done || dm_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_port", {31'd0, dm_done}, {31'd0, e[16]});
          check("done_rdata", {16'd0, dm_done ? dm_rdata : if_rdata}, {16'd0, e[15:0]});
        end
      end
      if (!mem_en) check("we_idle", {31'd0, mem_we}, 32'd0);

      // start of an access: who should have won, from requests seen last cycle
      if (mem_en && !prev_en) begin
        if (!prev_if_req && !prev_dm_req) check("spurious_grant", 32'd1, 32'd0);
        if (prev_if_req && prev_dm_req) g = ~ref_last;
        else                            g = prev_dm_req;
        ref_last = g;
        cur_g    = g;
        busy_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(1, 4);
        grant_log.push_back(sel);
        check("grant", {31'd0, sel}, {31'd0, g});
      end
      if (prev_en && !mem_en) check("en_cycles", busy_cnt, mem_lat);

      if (mem_en) begin
        busy_cnt++;
        check("sel_busy", {31'd0, sel}, {31'd0, cur_g});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, cur_g ? dm_addr : if_addr});
        check("mem_we", {31'd0, mem_we}, {31'd0, cur_g & dm_we});
        if (cur_g && dm_we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, dm_wdata});
      end

      // memory responder; stray ready pulses outside an access must be ignored
      if (mem_en) new_r = (busy_cnt >= mem_lat);
      else        new_r = ($urandom_range(0, 3) == 0);
      new_d     = fixed_en ? fixed_d : 16'($urandom);
      mem_r     = new_r;
      mem_rdata = new_d;
      expect_done = mem_en && new_r;
      if (expect_done) begin
        if (cur_g && dm_we) begin
          exp_q.push_back({1'b1, ref_dm_rd});
        end else if (cur_g) begin
          ref_dm_rd = new_d;
          exp_q.push_back({1'b1, new_d});
        end else begin
          ref_if_rd = new_d;
          exp_q.push_back({1'b0, new_d});
        end
      end
      prev_en = mem_en;
    end
    prev_if_req = if_req;
    prev_dm_req = dm_req;
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
    mem_r = 1'b0; mem_rdata = 16'h0;

    // 1: reset for 2 cycles, all outputs 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
    check("rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
    check("rst_done", {30'd0, if_done, dm_done}, 32'd0);
    check("rst_mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_sel", {31'd0, sel}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 3 (first contention after reset): IF first, then DM
    grant_log.delete();
    fork
      if_access(16'h1000);
      dm_access(1'b0, 16'h2000, 16'h0);
    join
    check("contention_cnt", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("contention_first_if", {31'd0, grant_log[0]}, 32'd0);
      check("contention_then_dm", {31'd0, grant_log[1]}, 32'd1);
    end

    // 2: IF read, ready on 3rd BUSY cycle with 0x1234
    mem_lat = 3; fixed_en = 1'b1; fixed_d = 16'h1234;
    if_access(16'h3000);
    check("if_rdata_held", {16'd0, if_rdata}, 32'h1234);

    // 4: DM write, immediate ready, dm_rdata unchanged
    mem_lat = 1; fixed_d = 16'h5555;
    dm_access(1'b1, 16'h4000, 16'hBEEF);
    check("dm_rdata_after_write", {16'd0, dm_rdata}, {16'd0, ref_dm_rd});
    fixed_en = 1'b0;

    // 5: both requesting continuously -> alternating grants
    grant_log.delete();
    fork
      repeat (3) if_access(16'($urandom));
      repeat (3) dm_access(1'($urandom), 16'($urandom), 16'($urandom));
    join
    check("alt_cnt", grant_log.size(), 6);
    for (int i = 1; i < grant_log.size(); i++)
      check("alternate", {31'd0, grant_log[i]}, {31'd0, ~grant_log[i-1]});
    grant_log.delete();
    repeat (3) if_access(16'($urandom));
    check("if_alone_cnt", grant_log.size(), 3);
    foreach (grant_log[i]) check("if_alone", {31'd0, grant_log[i]}, 32'd0);

    // 6: reset in the 2nd BUSY cycle aborts without a done pulse
    mem_lat = 50;
    if_addr = 16'h5000;
    if_req  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_en && t < 20);
    check("abort_busy_seen", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_2nd_busy", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check("abort_no_done", {30'd0, if_done, dm_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_idle", {29'd0, mem_en, if_done, dm_done}, 32'd0);
    @(posedge clk);
    #1;
    mem_lat = 1;
    grant_log.delete();
    fork
      if_access(16'h6000);
      dm_access(1'b0, 16'h7000, 16'h0);
    join
    if (grant_log.size() > 0) check("post_abort_if_first", {31'd0, grant_log[0]}, 32'd0);
    else                      check("post_abort_grant", 32'd0, 32'd1);

    // randomized traffic
    rand_lat = 1'b1;
    fork
      repeat (20) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 if_access(16'($urandom));
      end
      repeat (20) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 dm_access(1'($urandom), 16'($urandom), 16'($urandom));
      end
    join

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
